fact_accel: RTL and testbench
=============================

// Module: fact_accel
// PURPOSE
//   Memory-mapped iterative factorial accelerator on the single-cycle MIPS data bus,
//   directly downstream of the core: it consumes we_dm/alu_out/wd_dm and returns read data.
//   Software writes n, pulses GO, polls STATUS, then reads RESULT = n!.
//   The top-level address decoder qualifies the write enable and steers rd into the core's rd_dm mux.
// PARAMETERS
//   WIDTH   32  data/result width; matches the core data bus
//   N_W     4   operand width; n is taken from wd[N_W-1:0]
//   N_MAX   12  largest n whose factorial fits in WIDTH bits; larger n raises err
// PORTS
//   clk     in   1      system clock; all state updates on the rising edge
//   rst     in   1      asynchronous, active-low reset
//   we      in   1      write strobe: core we_dm AND decoder select
//   a       in   2      word offset = core alu_out[3:2]
//   wd      in   WIDTH  write data = core wd_dm
//   rd      out  WIDTH  combinational read data for the selected offset
//   busy    out  1      high while state == CALC
// BEHAVIOUR
//   Register map (a): 0 N RW, low N_W bits, reads zero-extended
//     1 GO RW bit0; reads the last written value; writing wd[0]=1 is a start request
//     2 STATUS RO {30'b0, err, done}
//     3 RESULT RO
//   Writes to STATUS or RESULT are ignored. rd depends only on a (no we gating, no latency).
//   Reset (rst=0, asynchronous): state=IDLE; n, go, err, result, acc, cnt = 0; done=0; busy=0.
//   FSM states: IDLE, CALC, DONE. done = (state==DONE).
//   Start request = we && a==1 && wd[0]; accepted only in IDLE or DONE; ignored in CALC.
//   On accepted start: latch n_op = N register (or wd-independent current N value);
//     if n_op > N_MAX: err<=1, result<=0, state<=DONE.
//     else: err<=0, acc<=1, cnt<=n_op, state<=CALC.
//   CALC, each cycle: if cnt <= 1: result<=acc, state<=DONE;
//     else acc<=acc*cnt (truncated to WIDTH), cnt<=cnt-1.
//   Latency: done rises max(n,1) edges after the edge that accepts the start
//     (n=0 or 1 -> 1 edge, result 1; n=5 -> 5 edges, result 120); err path -> same edge.
//   DONE holds result/err until the next accepted start, which clears done on that edge.
//   Writing N during CALC updates the N register only; the running operation uses its latched operand.
//   Same-edge write of N and start cannot occur (one address per cycle); start uses the N value held before that edge.
//   Reset asserted mid-CALC aborts: IDLE, result=0, done=0; no partial result remains visible.
//   Multiplier product width is 2*WIDTH internally, but only the low WIDTH bits are kept;
//     for n<=N_MAX no truncation occurs.
// STRUCTURE
//   Shared package fact_pkg: state encoding localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2),
//     register offsets (FA_N=2'd0, FA_GO=2'd1, FA_STATUS=2'd2, FA_RESULT=2'd3), N_MAX.
//   Sub-module fact_core: FSM + acc/cnt datapath with go/n_op in, done/err/result out.
//   fact_accel wraps it with the register file, start decode and rd mux.
// TESTING
//   1 Reset: hold rst=0 with random bus activity -> rd=0 at all offsets, busy=0.
//   2 Write N=5, write GO=1 -> busy for 5 cycles; STATUS=32'h1; RESULT=32'd120.
//   3 N=0 and N=1 -> STATUS=1 one edge after start; RESULT=1.
//     N=12 -> RESULT=32'd479001600.
//   4 N=13 -> STATUS=32'h3 on the start edge; RESULT=0.
//     Then N=3 + GO -> err clears; RESULT=6.
//   5 N=6 + GO, write N=2 and GO=1 during CALC -> start ignored; RESULT=720.
//     A new GO from DONE -> RESULT=2.
//   6 N=10 + GO, pull rst low at cycle 4 of CALC -> STATUS=0, RESULT=0, busy=0.
//     Re-run after reset -> RESULT=3628800.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator: FSM encoding, register
// offsets and the largest operand whose factorial fits in 32 bits.
package fact_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] FA_N      = 2'd0;
   localparam logic [1:0] FA_GO     = 2'd1;
   localparam logic [1:0] FA_STATUS = 2'd2;
   localparam logic [1:0] FA_RESULT = 2'd3;

   localparam int N_MAX = 12;

endpackage : fact_pkg

// File: rtl/fact_core.sv
// Iterative factorial engine: multiplies a running accumulator by a down-counter
// once per cycle and parks the product in result when the counter reaches one.
module fact_core
   import fact_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_W   = 4,
   parameter int N_MAX = fact_pkg::N_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [N_W-1:0]   n_op,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [N_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;

   // Next-state and datapath update; a start is only honoured when no operation is running.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         IDLE, DONE: begin
            if (go) begin
               if (n_op > N_W'(N_MAX)) begin
                  err_d    = 1'b1;
                  result_d = {WIDTH{1'b0}};
                  state_d  = DONE;
               end else begin
                  err_d   = 1'b0;
                  acc_d   = {{(WIDTH-1){1'b0}}, 1'b1};
                  cnt_d   = n_op;
                  state_d = CALC;
               end
            end else begin
               state_d = state_q;
            end
         end
         CALC: begin
            // n=0 and n=1 both terminate on the first CALC cycle with acc still 1.
            if (cnt_q <= N_W'(1)) begin
               result_d = acc_q;
               state_d  = DONE;
            end else begin
               acc_d = acc_q * WIDTH'(cnt_q);
               cnt_d = cnt_q - N_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         acc_q    <= {WIDTH{1'b0}};
         cnt_q    <= {N_W{1'b0}};
         result_q <= {WIDTH{1'b0}};
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign busy   = (state_q == CALC);
   assign done   = (state_q == DONE);
   assign err    = err_q;
   assign result = result_q;

endmodule : fact_core

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: N/GO register file, start decode and a
// combinational read mux around the fact_core engine.
module fact_accel
   import fact_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_W   = 4,
   parameter int N_MAX = fact_pkg::N_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [1:0]       a,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd,
   output logic             busy
);

   logic [N_W-1:0]   n_q, n_d;
   logic             go_q, go_d;
   logic             start_s;
   logic             done_s;
   logic             err_s;
   logic [WIDTH-1:0] result_s;
   logic             wd_unused_s;

   assign wd_unused_s = ^wd[WIDTH-1:N_W];

   assign start_s = we && (a == FA_GO) && wd[0];

   // Software-visible N and GO registers; STATUS and RESULT writes fall through untouched.
   always_comb begin
      n_d  = n_q;
      go_d = go_q;
      if (we) begin
         case (a)
            FA_N:    n_d  = wd[N_W-1:0];
            FA_GO:   go_d = wd[0];
            default: n_d  = n_q;
         endcase
      end else begin
         n_d = n_q;
      end
   end

   // N and GO storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_q  <= {N_W{1'b0}};
         go_q <= 1'b0;
      end else begin
         n_q  <= n_d;
         go_q <= go_d;
      end
   end

   // The engine samples n_q, i.e. the operand held before the start edge.
   fact_core #(
      .WIDTH (WIDTH),
      .N_W   (N_W),
      .N_MAX (N_MAX)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .go     (start_s),
      .n_op   (n_q),
      .busy   (busy),
      .done   (done_s),
      .err    (err_s),
      .result (result_s)
   );

   // Read mux depends only on the offset, so the core sees data in the same cycle.
   always_comb begin
      rd = {WIDTH{1'b0}};
      case (a)
         FA_N:      rd = {{(WIDTH-N_W){1'b0}}, n_q};
         FA_GO:     rd = {{(WIDTH-1){1'b0}}, go_q};
         FA_STATUS: rd = {{(WIDTH-2){1'b0}}, err_s, done_s};
         FA_RESULT: rd = result_s;
         default:   rd = {WIDTH{1'b0}};
      endcase
   end

endmodule : fact_accel

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: directed table, hand-written corner
// sequences and randomized operands checked against a plain factorial model.
module tb_fact_accel;

   logic        clk;
   logic        rst;
   logic        we;
   logic [1:0]  a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        busy;

   int vectors;
   int miscompares;

   typedef struct {
      logic [3:0]  n;
      logic [31:0] res;
      logic [31:0] status;
      int          cycles;
   } vec_t;

   vec_t tbl[8];

   fact_accel dut (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .a    (a),
      .wd   (wd),
      .rd   (rd),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] fact_model(input int n);
      logic [31:0] r;
      r = 32'd1;
      if (n > 12) return 32'd0;
      for (int i = 2; i <= n; i++) r = r * i;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, got, got, exp, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      @(negedge clk);
      we = 1'b1;
      a  = addr;
      wd = data;
      @(posedge clk);
      #1;
      we = 1'b0;
      wd = 32'd0;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] v);
      a = addr;
      #1;
      v = rd;
   endtask

   // Wait for STATUS.done with a cycle budget; returns edges waited (or -1 on timeout).
   task automatic wait_done(output int cycles);
      logic [31:0] st;
      cycles = 0;
      bus_read(2'd2, st);
      while (st[0] !== 1'b1 && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
         bus_read(2'd2, st);
      end
      if (st[0] !== 1'b1) cycles = -1;
   endtask

   // Full operation from DONE/IDLE: program N, pulse GO, check latency/status/result.
   task automatic run_op(input string name, input logic [3:0] n, input logic [31:0] exp_res,
                         input logic [31:0] exp_st, input int exp_cyc);
      logic [31:0] v;
      int          cyc;
      bus_write(2'd0, {28'd0, n});
      bus_write(2'd1, 32'd1);
      if (exp_cyc == 0) begin
         bus_read(2'd2, v);
         check({name, " status@start"}, v, exp_st);
         check({name, " busy@start"}, {31'd0, busy}, 32'd0);
      end else begin
         check({name, " busy@start"}, {31'd0, busy}, 32'd1);
         wait_done(cyc);
         check({name, " latency"}, cyc, exp_cyc);
         bus_read(2'd2, v);
         check({name, " status"}, v, exp_st);
      end
      bus_read(2'd3, v);
      check({name, " result"}, v, exp_res);
   endtask

   initial begin
      logic [31:0] v;
      int          cyc;
      int          n;
      vectors     = 0;
      miscompares = 0;
      rst = 1'b0;
      we  = 1'b0;
      a   = 2'd0;
      wd  = 32'd0;

      tbl[0] = '{n: 4'd5,  res: 32'd120,       status: 32'h1, cycles: 5};
      tbl[1] = '{n: 4'd0,  res: 32'd1,         status: 32'h1, cycles: 1};
      tbl[2] = '{n: 4'd1,  res: 32'd1,         status: 32'h1, cycles: 1};
      tbl[3] = '{n: 4'd12, res: 32'd479001600, status: 32'h1, cycles: 12};
      tbl[4] = '{n: 4'd13, res: 32'd0,         status: 32'h3, cycles: 0};
      tbl[5] = '{n: 4'd3,  res: 32'd6,         status: 32'h1, cycles: 3};
      tbl[6] = '{n: 4'd15, res: 32'd0,         status: 32'h3, cycles: 0};
      tbl[7] = '{n: 4'd2,  res: 32'd2,         status: 32'h1, cycles: 2};

      // Reset held with random bus traffic: everything must read back zero.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         we = 1'($urandom);
         a  = 2'($urandom);
         wd = $urandom;
      end
      we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_read(2'(i), v);
         check($sformatf("reset rd[%0d]", i), v, 32'd0);
      end
      check("reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // N readback is zero-extended from the low four bits; GO reads last written bit.
      bus_write(2'd0, 32'hFFFF_FFF7);
      bus_read(2'd0, v);
      check("N readback", v, 32'd7);
      bus_write(2'd1, 32'd0);
      bus_read(2'd1, v);
      check("GO readback 0", v, 32'd0);
      bus_write(2'd3, 32'hDEAD_BEEF);
      bus_read(2'd3, v);
      check("RESULT write ignored", v, 32'd0);

      for (int i = 0; i < 8; i++)
         run_op($sformatf("tbl[%0d] n=%0d", i, tbl[i].n), tbl[i].n, tbl[i].res,
                tbl[i].status, tbl[i].cycles);
      bus_read(2'd1, v);
      check("GO readback 1", v, 32'd1);

      // Start during CALC is ignored; N register still takes the new value.
      bus_write(2'd0, 32'd6);
      bus_write(2'd1, 32'd1);
      bus_write(2'd0, 32'd2);
      bus_write(2'd1, 32'd1);
      check("busy after ignored GO", {31'd0, busy}, 32'd1);
      wait_done(cyc);
      check("n=6 finishes", {31'd0, cyc != -1}, 32'd1);
      bus_read(2'd3, v);
      check("n=6 result", v, 32'd720);
      bus_read(2'd0, v);
      check("N updated in CALC", v, 32'd2);
      bus_write(2'd1, 32'd1);
      wait_done(cyc);
      check("restart latency n=2", cyc, 2);
      bus_read(2'd3, v);
      check("restart result n=2", v, 32'd2);

      // Reset on the fourth CALC cycle aborts the operation.
      bus_write(2'd0, 32'd10);
      bus_write(2'd1, 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      bus_read(2'd2, v);
      check("abort status", v, 32'd0);
      bus_read(2'd3, v);
      check("abort result", v, 32'd0);
      check("abort busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op("rerun n=10", 4'd10, 32'd3628800, 32'h1, 10);

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         n = $urandom_range(0, 15);
         run_op($sformatf("rand[%0d] n=%0d", i, n), 4'(n), fact_model(n),
                (n > 12) ? 32'h3 : 32'h1, (n > 12) ? 0 : ((n < 1) ? 1 : n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_fact_accel
